xor_rr_scheduler: RTL and testbench
===================================

// Module: xor_rr_scheduler
//
// PURPOSE
//   Shares one registered WIDTH-bit XOR datapath between N_REQ requesters.
//   Arbitration is round-robin with a req/gnt/done handshake.
//   Each requester presents operands a_i, b_i and holds req_i. The block
//   grants one requester, latches its operands, computes y = a ^ b, and
//   pulses done. Sits between client logic and the shared XOR unit.
//
// PARAMETERS
//   N_REQ  4  number of requesters (>= 2)
//   WIDTH  8  operand/result width in bits
//
// PORTS
//   clk    in   1              rising-edge clock
//   rst    in   1              asynchronous, active-high reset
//   req    in   N_REQ          req[i]=1: requester i wants an operation
//   a_in   in   N_REQ*WIDTH    operand a; requester i at [i*WIDTH +: WIDTH]
//   b_in   in   N_REQ*WIDTH    operand b; same packing as a_in
//   gnt    out  N_REQ          one-hot grant, registered
//   busy   out  1              1 while in CALC or DONE
//   done   out  1              1-cycle pulse: y is valid for the granted requester
//   y      out  WIDTH          result register a ^ b of the granted requester
//
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE, gnt=0, busy=0, done=0, y=0, ptr=0.
//     Operand latches are cleared to 0. Asserting reset mid-operation aborts
//     the operation: no done pulse, and the outputs take their reset values
//     immediately.
//   - FSM, 3 states, transitions on the rising clk edge:
//     IDLE: if req != 0, select the winner w = first set req bit, scanning
//       ptr, ptr+1, ... with wrap modulo N_REQ. Latch a_in/b_in slice w.
//       Set gnt = 1<<w and busy=1, then go to CALC. If req == 0, stay in IDLE
//       with gnt=0.
//     CALC: y <= a_lat ^ b_lat; done <= 1; go to DONE.
//     DONE: done <= 0; gnt <= 0; busy <= 0; ptr <= (w+1) mod N_REQ; go to IDLE.
//   - Latency: req sampled at edge E -> gnt at E+1 -> done=1 and y valid for
//     the cycle after E+2. Throughput is one operation per 3 cycles.
//   - y holds its value until the next CALC or a reset.
//   - Operands are captured only at the grant edge. Later changes to
//     a_in/b_in or deassertion of req do not affect the result; the
//     operation still completes and done still pulses.
//   - A requester keeps req high to be served again. Arbitration is fair:
//     with all req high, grant order is 0,1,2,3,0,... from reset.
//   - Requests arriving during CALC/DONE are ignored until IDLE; there is no
//     queueing.
//   - Wrap-around: ptr = N_REQ-1 with only req[0] set -> grants 0.
//   - Inputs containing X/Z propagate X to y; no masking.
//
// CONFIGURATION
//   XOR_PARITY_EN defined:
//     - adds output port `parity` (1 bit) = ^y, registered in the same
//       cycle as y;
//     - parity resets to 0.
//   XOR_PARITY_EN undefined:
//     - no parity port and no parity logic;
//     - all other behaviour is identical.
//
// TESTING
//   1. Assert rst with req=4'b1111 -> gnt=0, busy=0, done=0, y=8'h00; after
//      release with req=0, the block stays in IDLE.
//   2. req=4'b0001, a0=8'hA5, b0=8'h0F -> gnt=0001 one cycle later, then
//      done=1 with y=8'hAA; gnt=0 after done.
//   3. req=4'b1111 held for 12 operations -> grant order 0,1,2,3,0,1,2,3,...
//      and done pulses every 3rd cycle.
//   4. Change a_in/b_in and drop req the cycle after the grant -> y equals
//      XOR of the originally latched operands and done still pulses.
//   5. Assert rst during CALC -> no done pulse, y=0, ptr=0; the next
//      req=4'b1000 grants 3.
//   6. With XOR_PARITY_EN, a=8'h01, b=8'h00 -> y=8'h01, parity=1;
//      a=8'h03, b=8'h00 -> parity=0.

Source files
------------

// File: rtl/xor_rr_scheduler_if.sv
// Handshake bundle between requesters and the shared XOR scheduler.
// The parity signal exists only when XOR_PARITY_EN is defined.
interface xor_rr_scheduler_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   done;
    logic [WIDTH-1:0]       y;
`ifdef XOR_PARITY_EN
    logic                   parity;

    modport master (output req, a_in, b_in, input gnt, busy, done, y, parity);
    modport slave  (input req, a_in, b_in, output gnt, busy, done, y, parity);
`else
    modport master (output req, a_in, b_in, input gnt, busy, done, y);
    modport slave  (input req, a_in, b_in, output gnt, busy, done, y);
`endif
endinterface

// File: rtl/xor_rr_scheduler.sv
// Round-robin scheduler sharing one registered XOR datapath between N_REQ requesters.
// Optional feature macro: XOR_PARITY_EN adds a registered parity output (^y).
module xor_rr_scheduler #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    xor_rr_scheduler_if.slave bus
);
    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q;
    logic [PtrW-1:0]  ptr_q;
    logic [PtrW-1:0]  cur_q;
    logic [WIDTH-1:0] a_lat_q;
    logic [WIDTH-1:0] b_lat_q;
    logic [N_REQ-1:0] gnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] y_q;
`ifdef XOR_PARITY_EN
    logic             parity_q;
`endif

    logic [PtrW-1:0]  win;
    logic [PtrW-1:0]  cand;
    logic             found;
    int               idx;

    // First requester at or after ptr_q, wrapping modulo N_REQ.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
            cand = PtrW'(idx);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            cur_q    <= '0;
            a_lat_q  <= '0;
            b_lat_q  <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y_q      <= '0;
`ifdef XOR_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        cur_q   <= win;
                        a_lat_q <= bus.a_in[win*WIDTH +: WIDTH];
                        b_lat_q <= bus.b_in[win*WIDTH +: WIDTH];
                        gnt_q   <= N_REQ'(1) << win;
                        busy_q  <= 1'b1;
                        state_q <= StCalc;
                    end else begin
                        gnt_q   <= '0;
                    end
                end
                StCalc: begin
                    y_q      <= a_lat_q ^ b_lat_q;
`ifdef XOR_PARITY_EN
                    parity_q <= ^(a_lat_q ^ b_lat_q);
`endif
                    done_q   <= 1'b1;
                    state_q  <= StDone;
                end
                StDone: begin
                    done_q  <= 1'b0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= (cur_q == PtrW'(N_REQ - 1)) ? '0 : cur_q + PtrW'(1);
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.y      = y_q;
`ifdef XOR_PARITY_EN
    assign bus.parity = parity_q;
`endif

endmodule

// File: tb/tb_xor_rr_scheduler.sv
// Directed bench for xor_rr_scheduler: scoreboard of expected grant/result per done pulse.
module tb_xor_rr_scheduler;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_done = 0;
    bit   ok;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [7:0] a_v[4];
    logic [7:0] b_v[4];

    xor_rr_scheduler_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

    xor_rr_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.a_in[i*8 +: 8] = a;
        bus.b_in[i*8 +: 8] = b;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Called from a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_op(input string tag, input logic [3:0] req_v, input logic [3:0] exp_gnt,
                         input logic [7:0] exp_y);
        bit seen;
        bus.req = req_v;
        exp_q.push_back('{gnt: exp_gnt, y: exp_y});
        @(negedge clk);
        check({tag, "_gnt"}, 32'(bus.gnt), 32'(exp_gnt));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        bus.req = '0;
        wait_done(seen);
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({tag, "_gnt_clr"}, 32'(bus.gnt), 32'd0);
        check({tag, "_busy_clr"}, 32'(bus.busy), 32'd0);
    endtask

    // Scoreboard: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_gnt", 32'(bus.gnt), 32'(mon_e.gnt));
                check("sb_y", 32'(bus.y), 32'(mon_e.y));
`ifdef XOR_PARITY_EN
                check("sb_parity", 32'(bus.parity), 32'(^mon_e.y));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset with all requests high
        rst      = 1'b1;
        bus.req  = 4'hF;
        bus.a_in = 32'($urandom);
        bus.b_in = 32'($urandom);
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_y", 32'(bus.y), 32'd0);
`ifdef XOR_PARITY_EN
        check("rst_parity", 32'(bus.parity), 32'd0);
`endif
        rst     = 1'b0;
        bus.req = '0;
        repeat (3) @(negedge clk);
        check("idle_gnt", 32'(bus.gnt), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Single request
        set_ops(0, 8'hA5, 8'h0F);
        do_op("single", 4'b0001, 4'b0001, 8'hAA);

        // Fair rotation from reset with all requests held
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = 8'($urandom);
            b_v[i] = 8'($urandom);
            set_ops(i, a_v[i], b_v[i]);
        end
        bus.req = 4'hF;
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back('{gnt: 4'(1 << (i % 4)), y: a_v[i % 4] ^ b_v[i % 4]});
            wait_done(ok);
            check("rr_done_seen", 32'(ok), 32'd1);
            if (i > 0) check("rr_spacing", 32'(cyc - last_done), 32'd3);
            last_done = cyc;
            if (i == 11) bus.req = '0;
        end
        @(negedge clk);

        // Operands and req change after the grant edge
        set_ops(2, 8'h3C, 8'hC3);
        bus.req = 4'b0100;
        exp_q.push_back('{gnt: 4'b0100, y: 8'hFF});
        @(negedge clk);
        check("hold_gnt", 32'(bus.gnt), 32'b0100);
        set_ops(2, 8'h00, 8'h11);
        bus.req = '0;
        wait_done(ok);
        check("hold_done_seen", 32'(ok), 32'd1);
        @(negedge clk);

        // Wrap: pointer is 3, only req[0]
        set_ops(0, 8'h5A, 8'hFF);
        do_op("wrap", 4'b0001, 4'b0001, 8'hA5);

        // Reset during CALC aborts the operation
        set_ops(2, 8'h77, 8'h01);
        bus.req = 4'b0100;
        @(negedge clk);
        check("abort_gnt", 32'(bus.gnt), 32'b0100);
        bus.req = '0;
        rst = 1'b1;
        #1;
        check("abort_y", 32'(bus.y), 32'd0);
        check("abort_gnt_clr", 32'(bus.gnt), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        // Pointer reset to 0: all-request grant goes to 0
        do_op("ptr_reset", 4'hF, 4'b0001, 8'hA5);
        set_ops(3, 8'h12, 8'h34);
        do_op("req3", 4'b1000, 4'b1000, 8'h26);

        // Parity patterns (pointer wrapped to 0, only req[1])
        set_ops(1, 8'h01, 8'h00);
        do_op("par_odd", 4'b0010, 4'b0010, 8'h01);
        set_ops(1, 8'h03, 8'h00);
        do_op("par_even", 4'b0010, 4'b0010, 8'h03);

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
